// File: rtl/apu_port_pkg.sv
// Shared types and constants for the APU mailbox port responder.
// Out-port reset selection (APU_PORT_IPL_SIG_EN) is applied in apu_port_responder.
package apu_port_pkg;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned DATA_W    = 8;

    localparam logic [DATA_W-1:0] IPL_SIG0 = 8'hAA;
    localparam logic [DATA_W-1:0] IPL_SIG1 = 8'hBB;

    typedef enum logic {W_IDLE, W_ACTIVE} wr_state_e;
    typedef enum logic {R_IDLE, R_DRIVE}  rd_state_e;

    // One host bus beat: port select plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } host_beat_t;

endpackage

// File: rtl/apu_bus_sync.sv
// Multi-bit synchronizer for asynchronous host bus inputs.
// The low EDGE_W bits get one extra flop for rise/fall detection.
module apu_bus_sync #(
    parameter int unsigned  W       = 1,
    parameter int unsigned  EDGE_W  = 1,
    parameter int unsigned  STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      d,
    output logic [W-1:0]      level,
    output logic [EDGE_W-1:0] rise_c,
    output logic [EDGE_W-1:0] fall_c
);

    logic [W-1:0]      stage [STAGES];
    logic [EDGE_W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
            prev <= RST_VAL[EDGE_W-1:0];
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            prev <= stage[STAGES-1][EDGE_W-1:0];
        end
    end

    assign level  = stage[STAGES-1];
    assign rise_c = ~prev & stage[STAGES-1][EDGE_W-1:0];
    assign fall_c = prev & ~stage[STAGES-1][EDGE_W-1:0];

endmodule

// File: rtl/apu_port_responder.sv
// APU-side responder for the SNES CPU<->APU four-byte mailbox.
// Define APU_PORT_IPL_SIG_EN to reset out-ports 0/1 to the IPL ready signature.
module apu_port_responder
    import apu_port_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 APU_RSTn,
    input  logic [ADDR_W-1:0]    APU_A,
    input  logic                 APU_WEn,
    input  logic                 APU_RDn,
    input  logic [DATA_W-1:0]    APU_Din,
    output logic [DATA_W-1:0]    APU_Dout,
    output logic                 APU_DEn,
    input  logic [ADDR_W-1:0]    smp_addr,
    input  logic                 smp_wr,
    input  logic [DATA_W-1:0]    smp_wdata,
    output logic [DATA_W-1:0]    smp_rdata,
    input  logic                 smp_clr01,
    input  logic                 smp_clr23,
    output logic [NUM_PORTS-1:0] host_wr
);

    localparam int unsigned SYNC_W = ADDR_W + DATA_W + 3;

`ifdef APU_PORT_IPL_SIG_EN
    localparam logic [NUM_PORTS-1:0][DATA_W-1:0] OUT_RST =
        {DATA_W'(0), DATA_W'(0), IPL_SIG1, IPL_SIG0};
`else
    localparam logic [NUM_PORTS-1:0][DATA_W-1:0] OUT_RST = '0;
`endif

    logic [SYNC_W-1:0]    sync_lvl;
    logic [1:0]           sync_rise_c;
    logic [1:0]           sync_fall_c;
    logic                 wen_lvl;
    logic                 rdn_lvl;
    logic                 apu_run;
    host_beat_t           bus_c;
    host_beat_t           sample;
    wr_state_e            w_state, w_next;
    rd_state_e            r_state, r_next;
    logic                 commit_c;
    logic                 drive_c;
    logic [NUM_PORTS-1:0] clr_c;
    logic [DATA_W-1:0]    in_port  [NUM_PORTS];
    logic [DATA_W-1:0]    out_port [NUM_PORTS];

    // Strobes idle high; bit order {A, Din, RSTn, RDn, WEn}.
    apu_bus_sync #(
        .W       (SYNC_W),
        .EDGE_W  (2),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_W'(3'b111))
    ) u_sync (
        .clk    (CLK),
        .rst_n  (RSTn),
        .d      ({APU_A, APU_Din, APU_RSTn, APU_RDn, APU_WEn}),
        .level  (sync_lvl),
        .rise_c (sync_rise_c),
        .fall_c (sync_fall_c)
    );

    assign wen_lvl = sync_lvl[0];
    assign rdn_lvl = sync_lvl[1];
    assign apu_run = sync_lvl[2];
    assign bus_c   = host_beat_t'(sync_lvl[SYNC_W-1:3]);
    assign clr_c   = {smp_clr23, smp_clr23, smp_clr01, smp_clr01};

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        r_next = r_state;
        if (!apu_run) begin
            w_next = W_IDLE;
            r_next = R_IDLE;
        end else begin
            case (w_state)
                W_IDLE:   if (sync_fall_c[0]) w_next = W_ACTIVE;
                W_ACTIVE: if (sync_rise_c[0]) w_next = W_IDLE;
                default:  w_next = W_IDLE;
            endcase
            case (r_state)
                R_IDLE:   if (sync_fall_c[1]) r_next = R_DRIVE;
                R_DRIVE:  if (sync_rise_c[1]) r_next = R_IDLE;
                default:  r_next = R_IDLE;
            endcase
        end
    end

    // Never drive the bus while a host write strobe is low.
    always_comb begin
        commit_c = 1'b0;
        drive_c  = 1'b0;
        if (apu_run) begin
            commit_c = (w_state == W_ACTIVE) && sync_rise_c[0];
            drive_c  = (r_next == R_DRIVE) && wen_lvl && !rdn_lvl;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            host_wr  <= '0;
            APU_DEn  <= 1'b1;
            APU_Dout <= '0;
            sample   <= '0;
        end else if (!apu_run) begin
            host_wr  <= '0;
            APU_DEn  <= 1'b1;
            APU_Dout <= '0;
            sample   <= '0;
        end else begin
            host_wr <= commit_c ? (NUM_PORTS'(1) << sample.addr) : '0;
            APU_DEn <= ~drive_c;
            if (drive_c) APU_Dout <= out_port[bus_c.addr];
            // Last beat seen while WEn was low is the one committed.
            if (!wen_lvl) sample <= bus_c;
        end
    end

    // Host commit takes priority over an SMP clear on the same in-port.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                in_port[i]  <= '0;
                out_port[i] <= OUT_RST[i];
            end
        end else if (!apu_run) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                in_port[i]  <= '0;
                out_port[i] <= OUT_RST[i];
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (commit_c && sample.addr == ADDR_W'(i)) in_port[i] <= sample.data;
                else if (clr_c[i])                         in_port[i] <= '0;
                if (smp_wr && smp_addr == ADDR_W'(i))      out_port[i] <= smp_wdata;
            end
        end
    end

    assign smp_rdata = in_port[smp_addr];

endmodule

// File: tb/tb_apu_port_responder.sv
// Self-checking bench for apu_port_responder: directed steps plus randomized
// host/SMP traffic checked against a port-array model of the mailbox.
module tb_apu_port_responder;

    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       apu_rst_n;
    logic [1:0] apu_a;
    logic       apu_wen;
    logic       apu_rdn;
    logic [7:0] apu_din;
    logic [7:0] apu_dout;
    logic       apu_den;
    logic [1:0] smp_addr;
    logic       smp_wr;
    logic [7:0] smp_wdata;
    logic [7:0] smp_rdata;
    logic       smp_clr01;
    logic       smp_clr23;
    logic [3:0] host_wr;

    logic [7:0] in_m  [4];
    logic [7:0] out_m [4];
    int checks = 0;
    int errors = 0;

    apu_port_responder #(.SYNC_STAGES(SYNC)) dut (
        .CLK       (clk),
        .RSTn      (rst_n),
        .APU_RSTn  (apu_rst_n),
        .APU_A     (apu_a),
        .APU_WEn   (apu_wen),
        .APU_RDn   (apu_rdn),
        .APU_Din   (apu_din),
        .APU_Dout  (apu_dout),
        .APU_DEn   (apu_den),
        .smp_addr  (smp_addr),
        .smp_wr    (smp_wr),
        .smp_wdata (smp_wdata),
        .smp_rdata (smp_rdata),
        .smp_clr01 (smp_clr01),
        .smp_clr23 (smp_clr23),
        .host_wr   (host_wr)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) begin
            in_m[i]  = 8'h00;
            out_m[i] = 8'h00;
        end
`ifdef APU_PORT_IPL_SIG_EN
        out_m[0] = 8'hAA;
        out_m[1] = 8'hBB;
`endif
    endtask

    task automatic check_in_ports(input string tag);
        for (int i = 0; i < 4; i++) begin
            smp_addr = 2'(i);
            #1;
            chk($sformatf("%s in_port[%0d]", tag, i), smp_rdata, in_m[i]);
        end
    endtask

    // Host write; optionally pulse smp_clr01 in exactly the commit cycle.
    task automatic host_write(input logic [1:0] a, input logic [7:0] d,
                              input int low_cycles, input bit clr01_at_commit);
        logic [3:0] onehot;
        onehot   = 4'b0001 << a;
        apu_a    = a;
        apu_din  = d;
        apu_wen  = 1'b0;
        tick(low_cycles);
        apu_wen  = 1'b1;
        apu_a    = 2'($urandom);
        apu_din  = 8'($urandom);
        smp_addr = a;
        tick(SYNC);
        chk("host_wr before commit", 8'(host_wr), 8'h00);
        if (clr01_at_commit) smp_clr01 = 1'b1;
        tick(1);
        smp_clr01 = 1'b0;
        if (clr01_at_commit) begin
            in_m[0] = 8'h00;
            in_m[1] = 8'h00;
        end
        in_m[a] = d;
        chk("host_wr pulse", 8'(host_wr), 8'(onehot));
        chk("smp_rdata at pulse", smp_rdata, d);
        tick(1);
        chk("host_wr after pulse", 8'(host_wr), 8'h00);
    endtask

    task automatic smp_write(input logic [1:0] a, input logic [7:0] d);
        smp_addr  = a;
        smp_wdata = d;
        smp_wr    = 1'b1;
        tick(1);
        smp_wr    = 1'b0;
        out_m[a]  = d;
    endtask

    task automatic host_read(input logic [1:0] a, input string tag);
        apu_a   = a;
        apu_rdn = 1'b0;
        tick(SYNC);
        chk({tag, " DEn before enable"}, 8'(apu_den), 8'h01);
        tick(1);
        chk({tag, " DEn enable"}, 8'(apu_den), 8'h00);
        tick(1);
        chk({tag, " Dout"}, apu_dout, out_m[a]);
        apu_rdn = 1'b1;
        tick(SYNC);
        chk({tag, " DEn before release"}, 8'(apu_den), 8'h00);
        tick(1);
        chk({tag, " DEn release"}, 8'(apu_den), 8'h01);
    endtask

    initial begin
        logic [1:0] ra;
        logic [7:0] rd;
        rst_n = 1'b0; apu_rst_n = 1'b1; apu_a = '0; apu_wen = 1'b1; apu_rdn = 1'b1;
        apu_din = '0; smp_addr = '0; smp_wr = 1'b0; smp_wdata = '0;
        smp_clr01 = 1'b0; smp_clr23 = 1'b0;
        reset_model();
        tick(3);
        rst_n = 1'b1;
        tick(2);

        chk("reset DEn", 8'(apu_den), 8'h01);
        chk("reset Dout", apu_dout, 8'h00);
        chk("reset host_wr", 8'(host_wr), 8'h00);
        check_in_ports("reset");
        host_read(2'd0, "reset read p0");
        host_read(2'd1, "reset read p1");

        host_write(2'd2, 8'h5A, 8, 1'b0);
        check_in_ports("write p2");

        smp_write(2'd1, 8'hC3);
        tick(1);
        host_read(2'd1, "read p1");

        // Live data while reading port 0.
        apu_a = 2'd0; apu_rdn = 1'b0;
        tick(SYNC + 2);
        chk("live initial", apu_dout, out_m[0]);
        rd = out_m[0];
        smp_write(2'd0, 8'h11);
        chk("live 1clk 11", apu_dout, rd);
        tick(1);
        chk("live 2clk 11", apu_dout, 8'h11);
        smp_write(2'd0, 8'h22);
        chk("live 1clk 22", apu_dout, 8'h11);
        tick(1);
        chk("live 2clk 22", apu_dout, 8'h22);
        apu_rdn = 1'b1;
        tick(SYNC + 1);
        chk("live release", 8'(apu_den), 8'h01);

        // Commit vs clear collision.
        host_write(2'd1, 8'h4E, 6, 1'b0);
        host_write(2'd0, 8'h77, 6, 1'b0);
        host_write(2'd0, 8'hD2, 7, 1'b1);
        check_in_ports("commit vs clr01");

        host_write(2'd3, 8'h39, 6, 1'b0);
        smp_clr23 = 1'b1;
        tick(1);
        smp_clr23 = 1'b0;
        in_m[2] = 8'h00;
        in_m[3] = 8'h00;
        check_in_ports("clr23");

        // Both strobes low: write proceeds, bus never driven.
        apu_a = 2'd3; apu_din = 8'h6B; apu_wen = 1'b0; apu_rdn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("both low DEn", 8'(apu_den), 8'h01);
        end
        apu_wen = 1'b1; apu_rdn = 1'b1;
        tick(SYNC);
        chk("both low no early pulse", 8'(host_wr), 8'h00);
        tick(1);
        chk("both low pulse", 8'(host_wr), 8'h08);
        chk("both low DEn at commit", 8'(apu_den), 8'h01);
        in_m[3] = 8'h6B;
        tick(1);

        for (int k = 0; k < 10; k++) begin
            ra = 2'($urandom);
            rd = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                host_write(ra, rd, int'($urandom_range(SYNC + 3, SYNC + 8)), 1'b0);
                check_in_ports("random write");
            end else begin
                smp_write(ra, rd);
                tick(1);
                host_read(2'($urandom), "random read");
            end
        end

        // APU reset during a write.
        host_write(2'd1, 8'h3C, 6, 1'b0);
        smp_write(2'd2, 8'h99);
        apu_a = 2'd2; apu_din = 8'hE1; apu_wen = 1'b0;
        tick(6);
        apu_rst_n = 1'b0;
        tick(SYNC + 2);
        chk("apu reset DEn", 8'(apu_den), 8'h01);
        chk("apu reset host_wr", 8'(host_wr), 8'h00);
        apu_rst_n = 1'b1;
        tick(SYNC + 1);
        apu_wen = 1'b1;
        for (int i = 0; i < SYNC + 4; i++) begin
            tick(1);
            chk("dropped write host_wr", 8'(host_wr), 8'h00);
        end
        reset_model();
        check_in_ports("apu reset");
        host_read(2'd0, "post reset p0");
        host_read(2'd1, "post reset p1");
        host_read(2'd2, "post reset p2");

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_port_responder.md
# apu_port_responder

APU-side responder for the four-byte SNES CPU↔APU mailbox ($2140–$2143 on the CPU side, $F4–$F7 on the SMP side). It sits on the same GPIO-level bus that the core drives as initiator, with the same signals: APU_A, APU_WEn, APU_RDn, data, and an active-low data enable. It lets an internal SPC700 core replace the external APU board. Host strobes are asynchronous to CLK; the block synchronizes them, latches host writes into in-ports, serves host reads from out-ports, and gives the SMP a simple register port.

## Interface
- SYNC_STAGES, 2: synchronizer depth for host bus inputs (≥2).
- CLK  in  1  system clock, 50 MHz.
- RSTn  in  1  asynchronous, active-low reset.
- APU_RSTn  in  1  host-driven APU reset, active-low, asynchronous to CLK; synchronized internally.
- APU_A  in  2  host port select.
- APU_WEn  in  1  host write strobe, active-low.
- APU_RDn  in  1  host read strobe, active-low.
- APU_Din  in  8  host write data.
- APU_Dout  out  8  read data to host.
- APU_DEn  out  1  data output enable, active-low (0 = drive).
- smp_addr  in  2  SMP port select.
- smp_wr  in  1  SMP write pulse, 1 CLK.
- smp_wdata  in  8  SMP write data.
- smp_rdata  out  8  in-port[smp_addr], combinational.
- smp_clr01, smp_clr23  in  1  SMP control bits: clear in-ports 0/1 or 2/3 ($F1 bits 4/5).
- host_wr  out  4  one-hot, 1-CLK pulse on each committed host write.

## Operation
- State: in_port[0..3] (host→SMP) and out_port[0..3] (SMP→host), 8 bits each.
- Synchronization: APU_WEn, APU_RDn, APU_RSTn, APU_A and APU_Din each pass through SYNC_STAGES flops. WEn and RDn get one more flop for edge detection.
- Write FSM (W_IDLE, W_ACTIVE):
  - W_IDLE → W_ACTIVE on synchronized WEn falling edge.
  - While in W_ACTIVE, sample A and D every CLK.
  - W_ACTIVE → W_IDLE on synchronized WEn rising edge. On that transition, commit the last low-phase sample to in_port[A] and pulse host_wr[A].
- Read FSM (R_IDLE, R_DRIVE):
  - R_IDLE → R_DRIVE on synchronized RDn low; APU_DEn goes 0.
  - In R_DRIVE, APU_Dout is registered each CLK as out_port[A_sync], so it is live.
  - R_DRIVE → R_IDLE on synchronized RDn high; APU_DEn goes 1.
- SMP writes: smp_wr writes out_port[smp_addr] ← smp_wdata.
- SMP clears: smp_clr01 / smp_clr23 clear in_port pairs while high.
- Simultaneous host commit and SMP clear on the same in-port: the host commit wins.
- Synchronized APU_RSTn low: all ports go to reset values, both FSMs go idle, APU_DEn = 1, no host_wr pulse. A write in flight when reset arrives is dropped.
- WEn and RDn both low: the write FSM proceeds and APU_DEn stays 1, so the block never drives during a host write.

## Timing
- Reset values:
  - APU_Dout = 0, APU_DEn = 1, host_wr = 0.
  - in_port = 0.
  - out_port = 0, or the IPL signature (see Configuration).
- Host write commit and host_wr pulse: SYNC_STAGES+1 CLK after the WEn rising pin edge.
- Read enable: APU_DEn falls SYNC_STAGES+1 CLK after the RDn pin falls and rises SYNC_STAGES+1 CLK after RDn rises.
- Data validity: APU_Dout is valid 1 CLK after APU_DEn falls.
- Host requirements: strobes low ≥ SYNC_STAGES+3 CLK; A and Din stable ≥ SYNC_STAGES+1 CLK before WEn rises.
- SMP write visible on APU_Dout 2 CLK after smp_wr while reading.
- smp_rdata reflects a committed host write in the same CLK the host_wr pulse is high.

## Configuration
- APU_PORT_IPL_SIG_EN defined: out_port[0] and out_port[1] reset to 8'hAA and 8'hBB, the IPL ROM ready signature. out_port[2] and out_port[3] reset to 0. Host boot code sees "ready" immediately after reset.
- Not defined: all out_ports reset to 0.

## Structure
- Package apu_port_pkg:
  - NUM_PORTS = 4.
  - Write FSM state and read FSM state enums.
  - Out-port reset constants (IPL_SIG0 = 8'hAA, IPL_SIG1 = 8'hBB).
- Sub-module apu_bus_sync: a parameterized multi-bit synchronizer plus edge detect, giving synchronized level, rise and fall. Instanced once per strobe group.

## Test plan
- Host writes 8'h5A to port 2 (WEn low 8 CLK) → in_port[2] = 8'h5A, host_wr = 4'b0100 for 1 CLK, smp_rdata = 8'h5A with smp_addr = 2.
- SMP writes 8'hC3 to port 1, then host reads A = 1 → APU_DEn = 0 within 3 CLK, APU_Dout = 8'hC3, APU_DEn = 1 within 3 CLK after RDn rises.
- During a host read of port 0, SMP writes 8'h11 then 8'h22 → APU_Dout follows each value 2 CLK after the write.
- Host write to port 0 commits in the same CLK that smp_clr01 is high → in_port[0] = host data, in_port[1] = 0.
- APU_RSTn pulsed low mid-write (WEn still low) → no host_wr pulse, all in_ports = 0, APU_DEn = 1.
- Reset with APU_PORT_IPL_SIG_EN defined, host reads ports 0 and 1 → 8'hAA and 8'hBB. Without the macro → 8'h00 and 8'h00.
